power_cycle_sequencer: RTL and testbench

Sequencer for the low-power demo. It runs a repeating cycle of four steps: enable a programmable number of load-counter banks, wait for the supply current to settle, average several delta-sigma ADC samples of Icc, then put the load and the internal oscillator into standby for a fixed sleep period. It sits between the ADC front end (sample strobe and 8-bit code) and the power-consuming resources (the counter-bank enables and the oscillator STDBY pin). Its averaged result feeds the display conversion path.

---
 rtl/power_cycle_sequencer.sv | 166 ++++++++++++++++
 tb/tb_power_cycle_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_cycle_sequencer.sv
// power_cycle_sequencer: repeating SETTLE -> MEASURE -> SLEEP cycle that
// enables a programmable number of load banks, averages 2^AVG_SHIFT ADC
// samples of Icc, then parks the load and oscillator for a fixed sleep period.
module power_cycle_sequencer #(
  parameter int NUM_BANKS   = 11,
  parameter int SETTLE_CYC  = 16,
  parameter int SLEEP_CYC   = 64,
  parameter int AVG_SHIFT   = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 run,
  input  logic [3:0]           bank_sel,
  input  logic                 sample_rdy,
  input  logic [7:0]           adc_data,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 osc_stdby,
  output logic [7:0]           result,
  output logic                 result_vld,
  output logic                 meas_err,
  output logic                 busy
);

  localparam int PHASE_MAX = (SETTLE_CYC > SLEEP_CYC) ? SETTLE_CYC : SLEEP_CYC;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYC + 1);
  localparam int SW        = AVG_SHIFT + 1;
  localparam int NSAMP     = 1 << AVG_SHIFT;
  localparam int ACC_W     = 8 + AVG_SHIFT;

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, SLEEP} state_t;

  state_t               state, state_nx;
  logic [PW-1:0]        phase_cnt, phase_nx;
  logic [TW-1:0]        tmo_cnt, tmo_nx;
  logic [SW-1:0]        samp_cnt, samp_nx;
  logic [ACC_W-1:0]     acc, acc_nx, sum;
  logic [NUM_BANKS-1:0] bank_en_nx;
  logic [7:0]           result_nx;
  logic                 vld_nx, err_nx, stdby_nx, busy_nx;

  // Thermometer code: bits beyond NUM_BANKS do not exist, so any bank_sel
  // above NUM_BANKS naturally clamps to all-ones.
  function automatic logic [NUM_BANKS-1:0] therm(input logic [3:0] n);
    logic [NUM_BANKS-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) t[i] = (i < 32'(n));
    return t;
  endfunction

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nx   = state;
    phase_nx   = phase_cnt;
    tmo_nx     = tmo_cnt;
    samp_nx    = samp_cnt;
    acc_nx     = acc;
    bank_en_nx = bank_en;
    result_nx  = result;
    vld_nx     = 1'b0;
    err_nx     = 1'b0;
    sum        = acc + ACC_W'(adc_data);

    case (state)
      IDLE: begin
        if (run) begin
          state_nx   = SETTLE;
          bank_en_nx = therm(bank_sel);
          phase_nx   = '0;
        end
      end
      SETTLE: begin
        if (!run) begin
          state_nx   = IDLE;
          bank_en_nx = '0;
        end else if (phase_cnt == PW'(SETTLE_CYC - 1)) begin
          state_nx = MEASURE;
          acc_nx   = '0;
          samp_nx  = '0;
          tmo_nx   = '0;
        end else begin
          phase_nx = phase_cnt + 1'b1;
        end
      end
      MEASURE: begin
        // Abort beats a final strobe; a strobe beats an expiring timeout.
        if (!run) begin
          state_nx   = IDLE;
          bank_en_nx = '0;
          acc_nx     = '0;
          samp_nx    = '0;
        end else if (sample_rdy) begin
          tmo_nx = '0;
          if (samp_cnt == SW'(NSAMP - 1)) begin
            result_nx  = 8'(sum >> AVG_SHIFT);
            vld_nx     = 1'b1;
            state_nx   = SLEEP;
            bank_en_nx = '0;
            phase_nx   = '0;
          end else begin
            acc_nx  = sum;
            samp_nx = samp_cnt + 1'b1;
          end
        end else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          err_nx     = 1'b1;
          state_nx   = SLEEP;
          bank_en_nx = '0;
          phase_nx   = '0;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
        end
      end
      SLEEP: begin
        if (phase_cnt == PW'(SLEEP_CYC - 1)) begin
          phase_nx = '0;
          if (run) begin
            state_nx   = SETTLE;
            bank_en_nx = therm(bank_sel);
          end else begin
            state_nx = IDLE;
          end
        end else begin
          phase_nx = phase_cnt + 1'b1;
        end
      end
      default: begin
        state_nx   = IDLE;
        bank_en_nx = '0;
      end
    endcase

    stdby_nx = (state_nx == IDLE) || (state_nx == SLEEP);
    busy_nx  = (state_nx != IDLE);
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      tmo_cnt    <= '0;
      samp_cnt   <= '0;
      acc        <= '0;
      bank_en    <= '0;
      osc_stdby  <= 1'b1;
      result     <= '0;
      result_vld <= 1'b0;
      meas_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      phase_cnt  <= phase_nx;
      tmo_cnt    <= tmo_nx;
      samp_cnt   <= samp_nx;
      acc        <= acc_nx;
      bank_en    <= bank_en_nx;
      osc_stdby  <= stdby_nx;
      result     <= result_nx;
      result_vld <= vld_nx;
      meas_err   <= err_nx;
      busy       <= busy_nx;
    end
  end

endmodule

// File: tb/tb_power_cycle_sequencer.sv
// Bench for power_cycle_sequencer: directed scenarios followed by randomized
// segments, every cycle compared against a transaction-level reference model.
module tb_power_cycle_sequencer;

  localparam int NB      = 11;
  localparam int SETTLE  = 16;
  localparam int SLEEPC  = 64;
  localparam int AVG     = 2;
  localparam int TIMEOUT = 1024;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1, run = 1'b0, sample_rdy = 1'b0;
  logic [3:0]    bank_sel = '0;
  logic [7:0]    adc_data = '0;
  logic [NB-1:0] bank_en;
  logic          osc_stdby, result_vld, meas_err, busy;
  logic [7:0]    result;

  int checks = 0;
  int failures = 0;

  power_cycle_sequencer #(
    .NUM_BANKS(NB), .SETTLE_CYC(SETTLE), .SLEEP_CYC(SLEEPC),
    .AVG_SHIFT(AVG), .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst(rst), .run(run), .bank_sel(bank_sel),
    .sample_rdy(sample_rdy), .adc_data(adc_data), .bank_en(bank_en),
    .osc_stdby(osc_stdby), .result(result), .result_vld(result_vld),
    .meas_err(meas_err), .busy(busy)
  );

  // Free-running clock.
  always #5 clk_in = ~clk_in;

  // Reference model: phase plus remaining-cycle count and a sample queue.
  typedef enum {M_IDLE, M_SETTLE, M_MEAS, M_SLEEP} mmode_t;
  mmode_t         m_mode = M_IDLE;
  int             m_left, m_quiet;
  byte unsigned   m_q[$];
  logic [NB-1:0]  m_bank = '0;
  logic [7:0]     m_result = '0;
  logic           m_vld = 1'b0, m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter_settle(input logic [3:0] sel);
    int n;
    n = (sel > NB) ? NB : int'(sel);
    m_mode = M_SETTLE;
    m_left = SETTLE;
    m_bank = NB'((1 << n) - 1);
  endtask

  task automatic enter_sleep();
    m_mode = M_SLEEP;
    m_left = SLEEPC;
    m_bank = '0;
  endtask

  task automatic model_step(input logic rs, input logic rn, input logic [3:0] sel,
                            input logic rdy, input logic [7:0] d);
    int s;
    m_vld = 1'b0;
    m_err = 1'b0;
    if (rs) begin
      m_mode = M_IDLE; m_bank = '0; m_result = '0; m_q.delete();
    end else begin
      case (m_mode)
        M_IDLE:   if (rn) enter_settle(sel);
        M_SETTLE: begin
          if (!rn) begin m_mode = M_IDLE; m_bank = '0; end
          else begin
            m_left--;
            if (m_left == 0) begin m_mode = M_MEAS; m_q.delete(); m_quiet = 0; end
          end
        end
        M_MEAS: begin
          if (!rn) begin m_mode = M_IDLE; m_bank = '0; end
          else if (rdy) begin
            m_q.push_back(d);
            m_quiet = 0;
            if (m_q.size() == (1 << AVG)) begin
              s = 0;
              foreach (m_q[i]) s += m_q[i];
              m_result = 8'(s / (1 << AVG));
              m_vld = 1'b1;
              enter_sleep();
            end
          end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT) begin m_err = 1'b1; enter_sleep(); end
          end
        end
        M_SLEEP: begin
          m_left--;
          if (m_left == 0) begin
            if (rn) enter_settle(sel);
            else m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input logic rs, input logic rn, input logic [3:0] sel,
                      input logic rdy, input logic [7:0] d);
    rst = rs; run = rn; bank_sel = sel; sample_rdy = rdy; adc_data = d;
    @(posedge clk_in);
    model_step(rs, rn, sel, rdy, d);
    #1;
    check("bank_en",    32'(bank_en),    32'(m_bank));
    check("osc_stdby",  32'(osc_stdby),  32'(m_mode == M_IDLE || m_mode == M_SLEEP));
    check("result",     32'(result),     32'(m_result));
    check("result_vld", 32'(result_vld), 32'(m_vld));
    check("meas_err",   32'(meas_err),   32'(m_err));
    check("busy",       32'(busy),       32'(m_mode != M_IDLE));
  endtask

  task automatic run_to_measure(input logic [3:0] sel);
    for (int i = 0; i < 300 && m_mode != M_MEAS; i++) step(0, 1, sel, 0, 0);
    check("reach_measure", 32'(m_mode), 32'(M_MEAS));
  endtask

  task automatic strobes(input int n, input logic [3:0] sel);
    for (int i = 0; i < n; i++) step(0, 1, sel, 1, 8'($urandom));
  endtask

  initial begin
    int cnt;
    // Reset and first cycle with bank_sel=5.
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 8'hAA);
    check("rst_stdby", 32'(osc_stdby), 32'd1);
    check("rst_result", 32'(result), 32'd0);
    step(0, 1, 5, 0, 0);
    check("sel5_bank", 32'(bank_en), 32'h01F);
    check("sel5_stdby", 32'(osc_stdby), 32'd0);
    for (int i = 0; i < SETTLE; i++) step(0, 1, 4'($urandom), 1, 8'hFF);
    step(0, 1, 15, 1, 10);
    step(0, 1, 15, 1, 11);
    step(0, 1, 15, 1, 12);
    step(0, 1, 15, 1, 14);
    check("avg_result", 32'(result), 32'd11);
    check("avg_vld", 32'(result_vld), 32'd1);
    check("sleep_bank", 32'(bank_en), 32'd0);
    // Sleep length, re-latching a clamped bank_sel=15.
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      step(0, 1, 15, 0, 0);
      if (osc_stdby) cnt++; else break;
    end
    check("sleep_len", 32'(cnt), 32'd64);
    check("clamp_bank", 32'(bank_en), 32'h7FF);
    // Full timeout.
    run_to_measure(15);
    for (int i = 0; i < TIMEOUT; i++) step(0, 1, 0, 0, 0);
    check("tmo_err", 32'(meas_err), 32'd1);
    check("tmo_hold", 32'(result), 32'd11);
    // bank_sel=0 still measures.
    run_to_measure(0);
    check("sel0_bank", 32'(bank_en), 32'd0);
    strobes(4, 0);
    check("sel0_vld", 32'(result_vld), 32'd1);
    // Strobe on the last timeout cycle wins.
    run_to_measure(3);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 1, 3, 0, 0);
    step(0, 1, 3, 1, 8'd200);
    check("late_no_err", 32'(meas_err), 32'd0);
    strobes(3, 3);
    check("late_vld", 32'(result_vld), 32'd1);
    // Abort after two samples.
    run_to_measure(7);
    strobes(2, 7);
    step(0, 0, 7, 1, 8'd9);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_stdby", 32'(osc_stdby), 32'd1);
    check("abort_vld", 32'(result_vld), 32'd0);
    // Drop run during sleep: full sleep then idle.
    run_to_measure(2);
    strobes(4, 2);
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 2, 0, 0);
      if (busy) cnt++; else break;
    end
    check("sleep_norun", 32'(cnt), 32'd64);
    // Reset on the final strobe.
    run_to_measure(4);
    strobes(3, 4);
    step(1, 1, 4, 1, 8'd55);
    check("rst_final_result", 32'(result), 32'd0);
    check("rst_final_vld", 32'(result_vld), 32'd0);
    check("rst_final_busy", 32'(busy), 32'd0);

    // Randomized segments with varying run/strobe densities.
    for (int seg = 0; seg < 40; seg++) begin
      int len, run_pct, rdy_pct;
      case ($urandom_range(0, 3))
        0:       begin len = 1200; run_pct = 100; rdy_pct = 0;  end
        1:       begin len = 300;  run_pct = 99;  rdy_pct = 30; end
        2:       begin len = 400;  run_pct = 97;  rdy_pct = 2;  end
        default: begin len = 200;  run_pct = 70;  rdy_pct = 50; end
      endcase
      for (int c = 0; c < len; c++)
        step($urandom_range(0, 1499) == 0,
             $urandom_range(0, 99) < run_pct,
             4'($urandom),
             $urandom_range(0, 99) < rdy_pct,
             8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
